// File: rtl/mem_unit.sv
//==============================================================================
// Module      : mem_unit
// Description : Single-port synchronous memory responder with a fixed,
//               parameterised access latency. Optional busy-request error
//               flag enabled by defining MEM_BUSY_ERR_EN.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 2     // legal range 1..15 (4-bit counter)
) (
    input  logic                  I_clk,
    input  logic                  I_reset,
    input  logic                  I_execute,
    input  logic                  I_we,
    input  logic [ADDR_WIDTH-1:0] I_addr,
    input  logic [DATA_WIDTH-1:0] I_data,
    output logic                  O_ready,
    output logic                  O_data_ready,
    output logic [DATA_WIDTH-1:0] O_data,
    output logic                  O_error
);

    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WAIT  = 1'b1;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  ready_q, ready_d;
    logic                  data_ready_q, data_ready_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  req_we_q, req_we_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;
    logic                  mem_wr;

    // State register and control outputs
    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            ready_q      <= 1'b1;
            data_ready_q <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            data_ready_q <= data_ready_d;
            data_q       <= data_d;
        end
    end

    // Request capture needs no reset: only consumed while in WAIT
    always_ff @(posedge I_clk) begin
        req_we_q    <= req_we_d;
        req_addr_q  <= req_addr_d;
        req_wdata_q <= req_wdata_d;
    end

    // A reset in the completion cycle must abort the write
    always_ff @(posedge I_clk) begin
        if (mem_wr && !I_reset) begin
            mem[req_addr_q] <= req_wdata_q;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (I_execute)     state_d = ST_WAIT;
            ST_WAIT: if (cnt_q == 4'd0) state_d = ST_IDLE;
            default:                    state_d = ST_IDLE;
        endcase
    end

    // Output and datapath logic
    always_comb begin
        cnt_d        = cnt_q;
        ready_d      = ready_q;
        data_ready_d = 1'b0;
        data_d       = data_q;
        req_we_d     = req_we_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        mem_wr       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (I_execute) begin
                    req_we_d    = I_we;
                    req_addr_d  = I_addr;
                    req_wdata_d = I_data;
                    cnt_d       = CNT_LOAD;
                    ready_d     = 1'b0;
                end
            end
            ST_WAIT: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    ready_d = 1'b1;
                    if (req_we_q) begin
                        mem_wr = 1'b1;
                    end else begin
                        data_d       = mem[req_addr_q];
                        data_ready_d = 1'b1;
                    end
                end
            end
            default: begin
                cnt_d = 4'd0;
            end
        endcase
    end

`ifdef MEM_BUSY_ERR_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q | ((state_q == ST_WAIT) && I_execute);
    end

    always_ff @(posedge I_clk) begin
        if (I_reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign O_error = error_q;
`else
    assign O_error = 1'b0;
`endif

    assign O_ready      = ready_q;
    assign O_data_ready = data_ready_q;
    assign O_data       = data_q;

endmodule

`default_nettype wire

// File: doc/mem_unit.md
# mem_unit

Single-port synchronous memory responder that answers the control unit's memory handshake. It accepts one read or write request per `I_execute` pulse and reports completion through `O_ready` and `O_data_ready` after a fixed, parameterised access latency. It sits between the control unit and the register/ALU datapath, serving both instruction fetch and READ/WRITE data accesses.

## Interface
- `ADDR_WIDTH`, default 8: address width; memory depth is 2^ADDR_WIDTH words.
- `DATA_WIDTH`, default 16: word width.
- `LATENCY`, default 2: cycles from request acceptance to completion; legal range is 1..15.

- `I_clk` input 1: clock; all state changes on the rising edge.
- `I_reset` input 1: synchronous, active-high reset.
- `I_execute` input 1: request strobe, one cycle wide.
- `I_we` input 1: 1 = write, 0 = read; sampled with `I_execute`.
- `I_addr` input ADDR_WIDTH: word address; sampled with `I_execute`.
- `I_data` input DATA_WIDTH: write data; sampled with `I_execute`.
- `O_ready` output 1: idle and able to accept a request. Also signals write completion.
- `O_data_ready` output 1: one-cycle pulse; `O_data` is valid for a completed read.
- `O_data` output DATA_WIDTH: last read word, held until the next read completes.
- `O_error` output 1: sticky protocol-error flag (see Configuration).

## Operation
- States: IDLE, WAIT. A 4-bit down-counter `cnt` runs in WAIT.
- IDLE, `I_execute`=1 at an edge:
  - latch `I_we`, `I_addr`, `I_data`;
  - `O_ready`<=0, `cnt`<=LATENCY-1, go to WAIT.
- IDLE, `I_execute`=0: hold.
- WAIT, `cnt`!=0: `cnt`<=`cnt`-1.
- WAIT, `cnt`==0, access performed at this edge:
  - read: `O_data`<=mem[addr], `O_data_ready`<=1;
  - write: mem[addr]<=data;
  - in both cases `O_ready`<=1 and go to IDLE.
- `O_data_ready` clears on the following edge unconditionally.
- `I_execute` while in WAIT: the request is ignored and the in-flight access is unaffected; see `MEM_BUSY_ERR_EN`.
- Address is full-width; no wrap logic. The maximum address 2^ADDR_WIDTH-1 is valid.
- Memory contents are not initialised or cleared by reset.
- Reset values: state IDLE, `O_ready`=1, `O_data_ready`=0, `O_data`=0, `O_error`=0, `cnt`=0.
- Reset mid-operation aborts the access: no memory write occurs and no `O_data_ready` pulse is produced.
- Reset has priority over `I_execute` in the same cycle.

## Timing
- If the request is sampled at edge t, the access completes at edge t+LATENCY:
  - `O_ready` is low from t to t+LATENCY;
  - `O_ready` is high, and `O_data_ready` pulses (reads), in the cycle after t+LATENCY.
- With LATENCY=1, `O_ready` is low for exactly one cycle.
- The earliest next request is sampled at edge t+LATENCY+1. Back-to-back throughput is one access per LATENCY+1 cycles.
- A read following a write to the same address returns the new data; accesses are fully serialised.
- `O_data` changes only at read completion edges.

## Configuration
- `MEM_BUSY_ERR_EN` defined:
  - `I_execute`=1 sampled in WAIT sets `O_error`<=1;
  - `O_error` stays set until `I_reset`.
- `MEM_BUSY_ERR_EN` undefined: the `O_error` port is present but tied to 0; busy requests are silently dropped.

## Test plan
- Reset, then write 0xBEEF to 0x12, then read 0x12, with LATENCY=2:
  - `O_ready` is low for 2 cycles per access;
  - `O_data_ready` pulses once;
  - `O_data`=0xBEEF.
- Latency sweep, LATENCY=1 and LATENCY=5: `O_data_ready` appears exactly LATENCY+1 cycles after the `I_execute` cycle; `O_ready` is low for exactly LATENCY cycles.
- Write 0xA5A5 to 0xFF and 0x0001 to 0x00, then read both: 0xA5A5 and 0x0001 are returned, with no aliasing at the maximum address.
- Pulse `I_execute` (write 0x1234 to 0x05) during WAIT of a read of 0x05:
  - the read returns the old value;
  - 0x05 is unchanged afterwards;
  - `O_error`=1 with the macro defined, 0 without it.
- Assert `I_reset` one cycle into a write of 0x7777 to 0x20 (prior content 0x0000):
  - next cycle `O_ready`=1 and `O_data_ready`=0;
  - a subsequent read of 0x20 returns 0x0000.
- Issue the next request on the first cycle `O_ready` is high, for 8 consecutive accesses: all are accepted, with no lost or duplicated `O_data_ready` pulses.
